// File: rtl/dff_shreg_if.sv
// Control, data and status bundle of the dff_shreg shift register.
// The master drives the operation; the slave (the register) drives the status.
interface dff_shreg_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic [CW-1:0]    cnt;
  logic             drained;
  logic             done;

  modport master (
    output en, mode, sin, d,
    input  q, sout_l, sout_r, cnt, drained, done
  );

  modport slave (
    input  en, mode, sin, d,
    output q, sout_l, sout_r, cnt, drained, done
  );
endinterface

// File: rtl/dff_shreg.sv
// Bidirectional shift register with parallel load, a saturating count of
// shifts since the last load, and a one-cycle done pulse on reaching WIDTH.
module dff_shreg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  dff_shreg_if.slave  bus
);
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        MODE_HOLD: ;
        MODE_LEFT: begin
          q_d   = {q_q[WIDTH-2:0], bus.sin};
          shift = 1'b1;
        end
        MODE_RIGHT: begin
          q_d   = {bus.sin, q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = bus.d;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Count saturates at WIDTH; done fires only on the WIDTH-1 -> WIDTH step.
    if (shift && (cnt_q != CNT_MAX)) begin
      cnt_d  = cnt_q + CW'(1);
      done_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RST_VAL;
      cnt_q  <= CNT_MAX;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.sout_l  = q_q[WIDTH-1];
  assign bus.sout_r  = q_q[0];
  assign bus.cnt     = cnt_q;
  assign bus.drained = (cnt_q == CNT_MAX);
  assign bus.done    = done_q;
endmodule

// File: tb/tb_dff_shreg.sv
// Directed bench for dff_shreg (WIDTH=8, RST_VAL=0) with hand-computed
// expectations; each scenario task checks its own results.
module tb_dff_shreg;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dff_shreg_if #(.WIDTH(8)) bus ();

  dff_shreg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic [1:0] mode, input logic sin,
                       input logic [7:0] d);
    bus.en   = en;
    bus.mode = mode;
    bus.sin  = sin;
    bus.d    = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b11, 1'b0, 8'hFF);
    step();
    rst = 1'b0;
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", bus.q); end
    checks++; if (bus.cnt !== 4'd8) begin errors++; $display("FAIL reset_cnt got %0d exp 8", bus.cnt); end
    checks++; if (bus.drained !== 1'b1) begin errors++; $display("FAIL reset_drained got %b exp 1", bus.drained); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
  endtask

  task automatic test_left_shift();
    logic [7:0] exp_sl;
    exp_sl = 8'b1010_0101;
    drive(1'b1, 2'b11, 1'b0, 8'hA5);
    step();
    checks++; if (bus.q !== 8'hA5) begin errors++; $display("FAIL left_load_q got %h exp a5", bus.q); end
    checks++; if (bus.cnt !== 4'd0) begin errors++; $display("FAIL left_load_cnt got %0d exp 0", bus.cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.sout_l !== exp_sl[7-i]) begin
        errors++; $display("FAIL left_sout_l[%0d] got %b exp %b", i, bus.sout_l, exp_sl[7-i]);
      end
      drive(1'b1, 2'b01, 1'b0, 8'h00);
      step();
      checks++;
      if (bus.done !== (i == 7)) begin
        errors++; $display("FAIL left_done[%0d] got %b exp %b", i, bus.done, (i == 7));
      end
    end
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL left_end_q got %h exp 00", bus.q); end
    checks++; if (bus.cnt !== 4'd8) begin errors++; $display("FAIL left_end_cnt got %0d exp 8", bus.cnt); end
    checks++; if (bus.drained !== 1'b1) begin errors++; $display("FAIL left_end_drained got %b exp 1", bus.drained); end
    drive(1'b1, 2'b01, 1'b1, 8'h00);
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL left_sat_done got %b exp 0", bus.done); end
    checks++; if (bus.cnt !== 4'd8) begin errors++; $display("FAIL left_sat_cnt got %0d exp 8", bus.cnt); end
    checks++; if (bus.q !== 8'h01) begin errors++; $display("FAIL left_sat_q got %h exp 01", bus.q); end
  endtask

  task automatic test_right_shift();
    logic [7:0] exp_q [3];
    exp_q = '{8'h80, 8'hC0, 8'hE0};
    drive(1'b1, 2'b11, 1'b0, 8'h00);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 1'b1, 8'h00);
      step();
      checks++;
      if (bus.q !== exp_q[i]) begin
        errors++; $display("FAIL right_q[%0d] got %h exp %h", i, bus.q, exp_q[i]);
      end
    end
    checks++; if (bus.cnt !== 4'd3) begin errors++; $display("FAIL right_cnt got %0d exp 3", bus.cnt); end
    checks++; if (bus.drained !== 1'b0) begin errors++; $display("FAIL right_drained got %b exp 0", bus.drained); end
    checks++; if (bus.sout_r !== 1'b0) begin errors++; $display("FAIL right_sout_r got %b exp 0", bus.sout_r); end
    checks++; if (bus.sout_l !== 1'b1) begin errors++; $display("FAIL right_sout_l got %b exp 1", bus.sout_l); end
  endtask

  task automatic test_enable();
    drive(1'b1, 2'b11, 1'b0, 8'h3C);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b01, 1'b1, 8'hFF);
      step();
      checks++; if (bus.q !== 8'h3C) begin errors++; $display("FAIL en_q[%0d] got %h exp 3c", i, bus.q); end
      checks++; if (bus.cnt !== 4'd0) begin errors++; $display("FAIL en_cnt[%0d] got %0d exp 0", i, bus.cnt); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL en_done[%0d] got %b exp 0", i, bus.done); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b00, 1'b1, 8'hFF);
      step();
      checks++; if (bus.q !== 8'h3C) begin errors++; $display("FAIL hold_q[%0d] got %h exp 3c", i, bus.q); end
      checks++; if (bus.cnt !== 4'd0) begin errors++; $display("FAIL hold_cnt[%0d] got %0d exp 0", i, bus.cnt); end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 2'b11, 1'b0, 8'h3C);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 1'b0, 8'h00);
      step();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_done[%0d] got %b exp 0", i, bus.done); end
    end
    checks++; if (bus.q !== 8'hE0) begin errors++; $display("FAIL mid_pre_q got %h exp e0", bus.q); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL mid_rst_q got %h exp 00", bus.q); end
    checks++; if (bus.cnt !== 4'd8) begin errors++; $display("FAIL mid_rst_cnt got %0d exp 8", bus.cnt); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b exp 0", bus.done); end
    // First edge out of reset shifts normally, from a saturated count.
    drive(1'b1, 2'b01, 1'b1, 8'h00);
    step();
    checks++; if (bus.q !== 8'h01) begin errors++; $display("FAIL mid_post_q got %h exp 01", bus.q); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_post_done got %b exp 0", bus.done); end
  endtask

  task automatic test_load_after_done();
    drive(1'b1, 2'b11, 1'b0, 8'h00);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b01, 1'b1, 8'h00);
      step();
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL lad_done_pre got %b exp 1", bus.done); end
    checks++; if (bus.q !== 8'hFF) begin errors++; $display("FAIL lad_q_pre got %h exp ff", bus.q); end
    drive(1'b1, 2'b11, 1'b0, 8'h5A);
    step();
    checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL lad_q got %h exp 5a", bus.q); end
    checks++; if (bus.cnt !== 4'd0) begin errors++; $display("FAIL lad_cnt got %0d exp 0", bus.cnt); end
    checks++; if (bus.drained !== 1'b0) begin errors++; $display("FAIL lad_drained got %b exp 0", bus.drained); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL lad_done got %b exp 0", bus.done); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 8'h00);
    test_reset();
    test_left_shift();
    test_right_shift();
    test_enable();
    test_mid_reset();
    test_load_after_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
